// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port RAM between fetch and data ports
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  localparam logic [2:0] LAT_M1 = 3'(RAM_LATENCY - 1);
  state_t state;
  logic [2:0] cnt;
  logic last_d, sel_d, is_wr, gnt_i, gnt_d;
  logic [ADDR_W-1:0] addr_sel;
  // last_d resets high, so the first tie after reset goes to the fetch port
  assign gnt_d    = d_req & (~i_req | ~last_d);
  assign gnt_i    = i_req & ~gnt_d;
  assign addr_sel = gnt_d ? d_addr : i_addr;
  assign i_rdata  = i_ack ? mem_rdata : '0;
  assign d_rdata  = d_ack ? mem_rdata : '0;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state     <= IDLE;
      cnt       <= '0;
      last_d    <= 1'b1;
      sel_d     <= 1'b0;
      is_wr     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      mem_rstrb <= 1'b0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      mem_rstrb <= 1'b0;
      mem_wmask <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      case (state)
        IDLE:
          if (gnt_i | gnt_d) begin
            last_d    <= gnt_d;
            sel_d     <= gnt_d;
            is_wr     <= gnt_d & (|d_wmask);
            mem_addr  <= addr_sel & {{(ADDR_W-2){1'b1}}, 2'b00};
            mem_wdata <= gnt_d ? d_wdata : '0;
            mem_wmask <= gnt_d ? d_wmask : '0;
            mem_rstrb <= ~(gnt_d & (|d_wmask));
            state     <= ISSUE;
          end
        ISSUE:
          if (is_wr || RAM_LATENCY == 1) begin
            i_ack <= ~sel_d;
            d_ack <= sel_d;
            state <= ACK;
          end else begin
            cnt   <= LAT_M1;
            state <= WAIT;
          end
        WAIT:
          if (cnt == 3'd1) begin
            cnt   <= '0;
            i_ack <= ~sel_d;
            d_ack <= sel_d;
            state <= ACK;
          end else cnt <= cnt - 3'd1;
        ACK: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors on a latency-1 arbiter, hand sequences on a latency-3 one
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;
  logic        a_i_req, a_d_req, a_i_ack, a_d_ack, a_mem_rstrb;
  logic [31:0] a_i_addr, a_d_addr, a_d_wdata, a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_d_wmask, a_mem_wmask;
  logic        b_i_req, b_d_req, b_i_ack, b_d_ack, b_mem_rstrb;
  logic [31:0] b_i_addr, b_d_addr, b_d_wdata, b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_d_wmask, b_mem_wmask;
  logic [31:0] ram [0:63];
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .RAM_LATENCY(1)) dut_a (
    .CLK(CLK), .RESET(RESET),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_rdata(a_i_rdata), .i_ack(a_i_ack),
    .d_req(a_d_req), .d_addr(a_d_addr), .d_wmask(a_d_wmask), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ack(a_d_ack),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
    .mem_rstrb(a_mem_rstrb), .mem_rdata(a_mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .RAM_LATENCY(3)) dut_b (
    .CLK(CLK), .RESET(RESET),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
    .d_req(b_d_req), .d_addr(b_d_addr), .d_wmask(b_d_wmask), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
    .mem_rstrb(b_mem_rstrb), .mem_rdata(b_mem_rdata)
  );

  // latency-1 RAM with byte enables, preloaded while RESET is low
  always @(posedge CLK)
    if (!RESET) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[4]      <= 32'hDEADBEEF;
      a_mem_rdata <= 32'h0;
    end else begin
      if (a_mem_rstrb) a_mem_rdata <= ram[a_mem_addr[7:2]];
      for (int k = 0; k < 4; k++)
        if (a_mem_wmask[k]) ram[a_mem_addr[7:2]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
    end

  // the latency-3 instance only needs address-tagged data
  assign b_mem_rdata = {16'hCAFE, b_mem_addr[15:0]};

  typedef struct {
    logic ir; logic [31:0] ia;
    logic dr; logic [31:0] da; logic [3:0] dm; logic [31:0] dw;
    logic rs; logic [3:0] wm; logic [31:0] ad; logic [31:0] wd;
    logic ik; logic [31:0] ird;
    logic dk; logic [31:0] drd;
  } vec_t;
  vec_t tv [28];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic seen;

  initial begin
    tv = '{
      '{1, 'h10, 0, 'h00, 0, 0,          0, 0, 'h00, 0,          0, 0,           0, 0},
      '{1, 'h10, 0, 'h00, 0, 0,          1, 0, 'h10, 0,          0, 0,           0, 0},
      '{1, 'h10, 0, 'h00, 0, 0,          0, 0, 'h10, 0,          1, 'hDEADBEEF,  0, 0},
      '{0, 'h00, 1, 'h23, 3, 'h12345678, 0, 0, 'h10, 0,          0, 0,           0, 0},
      '{0, 'h00, 1, 'h23, 3, 'h12345678, 0, 3, 'h20, 'h12345678, 0, 0,           0, 0},
      '{0, 'h00, 1, 'h23, 3, 'h12345678, 0, 0, 'h20, 0,          0, 0,           1, 'hDEADBEEF},
      '{0, 'h00, 1, 'h20, 0, 0,          0, 0, 'h20, 0,          0, 0,           0, 0},
      '{0, 'h00, 1, 'h20, 0, 0,          1, 0, 'h20, 0,          0, 0,           0, 0},
      '{0, 'h00, 1, 'h20, 0, 0,          0, 0, 'h20, 0,          0, 0,           1, 'h5678},
      '{0, 'h00, 1, 'h20, 0, 0,          0, 0, 'h20, 0,          0, 0,           0, 0},
      '{0, 'h00, 1, 'h20, 0, 0,          1, 0, 'h20, 0,          0, 0,           0, 0},
      '{0, 'h00, 1, 'h20, 0, 0,          0, 0, 'h20, 0,          0, 0,           1, 'h5678},
      '{0, 'h00, 0, 'h20, 0, 0,          0, 0, 'h20, 0,          0, 0,           0, 0},
      '{0, 'h00, 0, 'h20, 0, 0,          0, 0, 'h20, 0,          0, 0,           0, 0},
      '{1, 'h10, 1, 'h20, 0, 0,          0, 0, 'h20, 0,          0, 0,           0, 0},
      '{1, 'h10, 1, 'h20, 0, 0,          1, 0, 'h10, 0,          0, 0,           0, 0},
      '{1, 'h10, 1, 'h20, 0, 0,          0, 0, 'h10, 0,          1, 'hDEADBEEF,  0, 0},
      '{1, 'h10, 1, 'h20, 0, 0,          0, 0, 'h10, 0,          0, 0,           0, 0},
      '{1, 'h10, 1, 'h20, 0, 0,          1, 0, 'h20, 0,          0, 0,           0, 0},
      '{1, 'h10, 1, 'h20, 0, 0,          0, 0, 'h20, 0,          0, 0,           1, 'h5678},
      '{1, 'h10, 1, 'h20, 0, 0,          0, 0, 'h20, 0,          0, 0,           0, 0},
      '{1, 'h10, 1, 'h20, 0, 0,          1, 0, 'h10, 0,          0, 0,           0, 0},
      '{1, 'h10, 1, 'h20, 0, 0,          0, 0, 'h10, 0,          1, 'hDEADBEEF,  0, 0},
      '{1, 'h10, 1, 'h20, 0, 0,          0, 0, 'h10, 0,          0, 0,           0, 0},
      '{1, 'h10, 1, 'h20, 0, 0,          1, 0, 'h20, 0,          0, 0,           0, 0},
      '{1, 'h10, 1, 'h20, 0, 0,          0, 0, 'h20, 0,          0, 0,           1, 'h5678},
      '{0, 'h00, 0, 'h00, 0, 0,          0, 0, 'h20, 0,          0, 0,           0, 0},
      '{0, 'h00, 0, 'h00, 0, 0,          0, 0, 'h20, 0,          0, 0,           0, 0}
    };
    RESET = 1'b0;
    {a_i_req, a_d_req, b_i_req, b_d_req} = '0;
    {a_i_addr, a_d_addr, a_d_wdata, b_i_addr, b_d_addr, b_d_wdata} = '0;
    {a_d_wmask, b_d_wmask} = '0;
    repeat (3) @(negedge CLK);
    chk("rst_a_ctl", {a_mem_rstrb, a_mem_wmask, a_i_ack, a_d_ack}, 0);
    chk("rst_a_addr", a_mem_addr, 0);
    chk("rst_a_wdata", a_mem_wdata, 0);
    chk("rst_a_rdata", {a_i_rdata, a_d_rdata}, 0);
    chk("rst_b_ctl", {b_mem_rstrb, b_mem_wmask, b_i_ack, b_d_ack, b_mem_addr}, 0);
    RESET = 1'b1;

    for (int k = 0; k < 28; k++) begin
      @(negedge CLK);
      a_i_req = tv[k].ir; a_i_addr = tv[k].ia;
      a_d_req = tv[k].dr; a_d_addr = tv[k].da; a_d_wmask = tv[k].dm; a_d_wdata = tv[k].dw;
      chk($sformatf("row%0d_ctl", k), {a_mem_rstrb, a_mem_wmask, a_i_ack, a_d_ack},
          {tv[k].rs, tv[k].wm, tv[k].ik, tv[k].dk});
      chk($sformatf("row%0d_addr", k), a_mem_addr, tv[k].ad);
      chk($sformatf("row%0d_wdata", k), (a_mem_wmask != 0) ? a_mem_wdata : 32'h0, tv[k].wd);
      chk($sformatf("row%0d_irdata", k), a_i_rdata, tv[k].ird);
      chk($sformatf("row%0d_drdata", k), a_d_rdata, tv[k].drd);
    end

    // latency 3: fetch issued cycle 1, acked cycle 4, next sample in cycle 5
    @(negedge CLK); b_i_req = 1'b1; b_i_addr = 32'h40;
    @(negedge CLK); chk("l3_issue", {b_mem_rstrb, b_mem_addr}, {1'b1, 32'h40});
    @(negedge CLK); chk("l3_wait1", {b_mem_rstrb, b_i_ack}, 0);
    @(negedge CLK); chk("l3_wait2", {b_mem_rstrb, b_i_ack}, 0);
    @(negedge CLK); chk("l3_ack", {b_i_ack, b_d_ack, b_i_rdata}, {1'b1, 1'b0, 32'hCAFE0040});
    @(negedge CLK); b_i_req = 1'b0; b_d_req = 1'b1; b_d_addr = 32'h80;
    chk("l3_idle", {b_mem_rstrb, b_i_ack, b_d_ack}, 0);
    @(negedge CLK); chk("l3_next_issue", {b_mem_rstrb, b_mem_addr}, {1'b1, 32'h80});
    repeat (3) @(negedge CLK);
    chk("l3_dack", {b_d_ack, b_d_rdata, b_i_rdata}, {1'b1, 32'hCAFE0080, 32'h0});

    // reset while a fetch sits in WAIT
    @(negedge CLK); b_d_req = 1'b0; b_i_req = 1'b1; b_i_addr = 32'h44;
    @(negedge CLK); chk("rw_issue", {b_mem_rstrb, b_mem_addr}, {1'b1, 32'h44});
    @(negedge CLK);
    chk("rw_in_wait", {b_mem_rstrb, b_i_ack}, 0);
    RESET = 1'b0; b_i_req = 1'b0;
    #1;
    chk("rw_async", {b_mem_rstrb, b_mem_wmask, b_i_ack, b_d_ack, b_mem_addr, b_i_rdata}, 0);
    @(negedge CLK); RESET = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      seen = seen | b_i_ack | b_d_ack | b_mem_rstrb;
    end
    chk("rw_no_ack", seen, 0);
    b_i_req = 1'b1; b_i_addr = 32'h48; b_d_req = 1'b1; b_d_addr = 32'h84;
    @(negedge CLK); chk("rw_tie_i", {b_mem_rstrb, b_mem_addr}, {1'b1, 32'h48});
    repeat (3) @(negedge CLK);
    chk("rw_fetch_ack", {b_i_ack, b_d_ack, b_i_rdata}, {1'b1, 1'b0, 32'hCAFE0048});
    @(negedge CLK); b_i_req = 1'b0;
    @(negedge CLK); chk("rw_then_d", {b_mem_rstrb, b_mem_addr}, {1'b1, 32'h84});
    b_d_req = 1'b0;
    repeat (4) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // both acks high together is never legal
  always @(negedge CLK)
    if (RESET) begin
      chk("ack_excl_a", a_i_ack & a_d_ack, 0);
      chk("ack_excl_b", b_i_ack & b_d_ack, 0);
      chk("strobe_excl", (a_mem_rstrb & (|a_mem_wmask)) | (b_mem_rstrb & (|b_mem_wmask)), 0);
    end
endmodule
